// File: rtl/driver_fifo_monitor_mc.sv
// -----------------------------------------------------------------------------
// driver_fifo_monitor_mc
//
// N-channel FIFO monitor. For every channel it follows FIFO occupancy from the
// write/read strobes and, while a program is active (RUN or DRAIN), builds two
// histograms: the interval between successive reads and the per-cycle
// occupancy. A small lifecycle FSM (IDLE -> RUN -> DRAIN -> DONE) gates the
// histograms; DRAIN waits for every channel to empty after end_program.
// Results are read back through a registered slave port.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   run_program       start / restart monitoring (IDLE or DONE only)
//   end_program       stop request, RUN -> DRAIN
//   fifo_wr, fifo_rd  per-channel write / read strobes
//   slave_addr        read address {20'b0, ch[3:0], type[1:0], bin[5:0]}
//   slave_rd          read strobe; data appears on slave_data_out next cycle
//   slave_data_out    registered read data, held between reads
//   active_program    high in RUN or DRAIN
//   mon_done          high in DONE
//   words_in_fifo     occupancy per channel, channel 0 in the LSBs
//   fifo_overrun      sticky: write while occupancy at maximum
//   fifo_underrun     sticky: read while occupancy zero
// -----------------------------------------------------------------------------
module driver_fifo_monitor_mc #(
    parameter int NUM_CH        = 4,
    parameter int CNT_SIZE      = 16,
    parameter int BIN_RANGE     = 8,
    parameter int MAX_CYCLE_CNT = 128,
    parameter int OCC_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run_program,
    input  logic                          end_program,
    input  logic [NUM_CH-1:0]             fifo_wr,
    input  logic [NUM_CH-1:0]             fifo_rd,
    input  logic [31:0]                   slave_addr,
    input  logic                          slave_rd,
    output logic [31:0]                   slave_data_out,
    output logic                          active_program,
    output logic                          mon_done,
    output logic [NUM_CH*OCC_WIDTH-1:0]   words_in_fifo,
    output logic [NUM_CH-1:0]             fifo_overrun,
    output logic [NUM_CH-1:0]             fifo_underrun
);

    localparam int NUM_BINS = MAX_CYCLE_CNT / BIN_RANGE;
    localparam int IC_W     = $clog2(MAX_CYCLE_CNT);
    localparam int BIN_SH   = $clog2(BIN_RANGE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   act_q, act_d;
    logic                   done_q, done_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rd_word;
    logic                   run_entry;
    logic                   counting;
    logic                   all_empty;

    logic [OCC_WIDTH-1:0]   occ_q [NUM_CH];
    logic [OCC_WIDTH-1:0]   occ_d [NUM_CH];
    logic [IC_W-1:0]        ic_q  [NUM_CH];
    logic [IC_W-1:0]        ic_d  [NUM_CH];
    logic [CNT_SIZE-1:0]    ibin_q [NUM_CH][NUM_BINS];
    logic [CNT_SIZE-1:0]    ibin_d [NUM_CH][NUM_BINS];
    logic [CNT_SIZE-1:0]    obin_q [NUM_CH][NUM_BINS];
    logic [CNT_SIZE-1:0]    obin_d [NUM_CH][NUM_BINS];
    logic [NUM_CH-1:0]      ovr_q, ovr_d;
    logic [NUM_CH-1:0]      udr_q, udr_d;

    // Saturating histogram bin increment.
    function automatic logic [CNT_SIZE-1:0] bin_sat_inc(input logic [CNT_SIZE-1:0] v);
        return (&v) ? v : v + CNT_SIZE'(1);
    endfunction

    // Interval counter step: restart at 1 on a read, otherwise count up and
    // stick at the top of the histogram span.
    function automatic logic [IC_W-1:0] ic_step(input logic [IC_W-1:0] ic, input logic rd);
        if (rd)
            return IC_W'(1);
        else if (ic == IC_W'(MAX_CYCLE_CNT - 1))
            return ic;
        else
            return ic + IC_W'(1);
    endfunction

    function automatic logic [5:0] ic_bin(input logic [IC_W-1:0] ic);
        return 6'(ic >> BIN_SH);
    endfunction

    // Occupancy above the histogram span lands in the last bin.
    function automatic logic [5:0] occ_bin(input logic [OCC_WIDTH-1:0] occ);
        logic [IC_W-1:0] clamped;
        if (32'(occ) > 32'(MAX_CYCLE_CNT - 1))
            clamped = IC_W'(MAX_CYCLE_CNT - 1);
        else
            clamped = IC_W'(occ);
        return 6'(clamped >> BIN_SH);
    endfunction

    always_comb begin
        all_empty = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (occ_q[c] != '0)
                all_empty = 1'b0;
        end
    end

    // Next-state logic: lifecycle FSM, occupancy, flags, interval counters
    // and histogram bins.
    always_comb begin
        state_d   = state_q;
        run_entry = 1'b0;
        occ_d     = occ_q;
        ic_d      = ic_q;
        ibin_d    = ibin_q;
        obin_d    = obin_q;
        ovr_d     = ovr_q;
        udr_d     = udr_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // run_program wins over a simultaneous end_program here
                if (run_program) begin
                    state_d   = ST_RUN;
                    run_entry = 1'b1;
                end
            end
            ST_RUN: begin
                if (end_program)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (all_empty)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        act_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d   = (state_d == ST_DONE);

        if (run_entry) begin
            ovr_d = '0;
            udr_d = '0;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            // Occupancy follows the strobes in every state; a simultaneous
            // write and read cancel out.
            case ({fifo_wr[c], fifo_rd[c]})
                2'b10: begin
                    if (&occ_q[c])
                        ovr_d[c] = 1'b1;
                    else
                        occ_d[c] = occ_q[c] + OCC_WIDTH'(1);
                end
                2'b01: begin
                    if (occ_q[c] == '0)
                        udr_d[c] = 1'b1;
                    else
                        occ_d[c] = occ_q[c] - OCC_WIDTH'(1);
                end
                default: ;
            endcase

            if (run_entry) begin
                ic_d[c] = '0;
                for (int b = 0; b < NUM_BINS; b++) begin
                    ibin_d[c][b] = '0;
                    obin_d[c][b] = '0;
                end
            end else if (counting) begin
                ic_d[c] = ic_step(ic_q[c], fifo_rd[c]);
                for (int b = 0; b < NUM_BINS; b++) begin
                    if (fifo_rd[c] && (ic_bin(ic_q[c]) == 6'(b)))
                        ibin_d[c][b] = bin_sat_inc(ibin_q[c][b]);
                    if (occ_bin(occ_q[c]) == 6'(b))
                        obin_d[c][b] = bin_sat_inc(obin_q[c][b]);
                end
            end
        end
    end

    // Slave read decode from the registered state.
    always_comb begin
        rd_word = '0;
        if (slave_addr[31:12] == '0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (slave_addr[11:8] == 4'(c)) begin
                    case (slave_addr[7:6])
                        2'd0: begin
                            for (int b = 0; b < NUM_BINS; b++)
                                if (slave_addr[5:0] == 6'(b))
                                    rd_word = 32'(ibin_q[c][b]);
                        end
                        2'd1: begin
                            for (int b = 0; b < NUM_BINS; b++)
                                if (slave_addr[5:0] == 6'(b))
                                    rd_word = 32'(obin_q[c][b]);
                        end
                        2'd2: begin
                            if (slave_addr[5:0] == 6'd0)
                                rd_word = {12'b0, state_q, ovr_q[c], udr_q[c], 16'(occ_q[c])};
                            else if (slave_addr[5:0] == 6'd1)
                                rd_word = 32'(ic_q[c]);
                        end
                        default: ;
                    endcase
                end
            end
        end
        rdata_d = slave_rd ? rd_word : rdata_q;
    end

    // ---- register stage: all monitor state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            ovr_q   <= '0;
            udr_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                occ_q[c] <= '0;
                ic_q[c]  <= '0;
                for (int b = 0; b < NUM_BINS; b++) begin
                    ibin_q[c][b] <= '0;
                    obin_q[c][b] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            ovr_q   <= ovr_d;
            udr_q   <= udr_d;
            occ_q   <= occ_d;
            ic_q    <= ic_d;
            ibin_q  <= ibin_d;
            obin_q  <= obin_d;
        end
    end

    always_comb begin
        words_in_fifo = '0;
        for (int c = 0; c < NUM_CH; c++)
            words_in_fifo[c*OCC_WIDTH +: OCC_WIDTH] = occ_q[c];
    end

    assign slave_data_out = rdata_q;
    assign active_program = act_q;
    assign mon_done       = done_q;
    assign fifo_overrun   = ovr_q;
    assign fifo_underrun  = udr_q;

endmodule

// File: tb/tb_driver_fifo_monitor_mc.sv
module tb_driver_fifo_monitor_mc;
    localparam int NUM_CH    = 4;
    localparam int CNT_SIZE  = 4;
    localparam int OCC_WIDTH = 16;

    logic                        clk;
    logic                        reset;
    logic                        run_program;
    logic                        end_program;
    logic [NUM_CH-1:0]           fifo_wr;
    logic [NUM_CH-1:0]           fifo_rd;
    logic [31:0]                 slave_addr;
    logic                        slave_rd;
    logic [31:0]                 slave_data_out;
    logic                        active_program;
    logic                        mon_done;
    logic [NUM_CH*OCC_WIDTH-1:0] words_in_fifo;
    logic [NUM_CH-1:0]           fifo_overrun;
    logic [NUM_CH-1:0]           fifo_underrun;

    driver_fifo_monitor_mc #(
        .NUM_CH(NUM_CH), .CNT_SIZE(CNT_SIZE), .BIN_RANGE(8),
        .MAX_CYCLE_CNT(128), .OCC_WIDTH(OCC_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .slave_addr(slave_addr), .slave_rd(slave_rd),
        .slave_data_out(slave_data_out), .active_program(active_program), .mon_done(mon_done),
        .words_in_fifo(words_in_fifo), .fifo_overrun(fifo_overrun), .fifo_underrun(fifo_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        resp_due = 1'b0;

    // A read issued at a clock edge has its data on slave_data_out after that edge.
    always @(posedge clk) resp_due <= slave_rd;

    // Scoreboard monitor.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (resp_due) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_response got=0x%08h", slave_data_out);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (slave_data_out !== e) begin
                        failures++;
                        $display("FAIL %s got=0x%08h want=0x%08h", n, slave_data_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] wr, input logic [3:0] rd, input logic run, input logic endp);
        fifo_wr = wr; fifo_rd = rd; run_program = run; end_program = endp;
        @(posedge clk); #1;
        fifo_wr = '0; fifo_rd = '0; run_program = 1'b0; end_program = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic rreg(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        slave_addr = addr; slave_rd = 1'b1;
        @(posedge clk); #1;
        slave_rd = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; run_program = 1'b0; end_program = 1'b0;
        fifo_wr = '0; fifo_rd = '0; slave_addr = '0; slave_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 64'(slave_data_out), 64'h0);
        chk("rst_active", 64'(active_program), 64'h0);
        chk("rst_done", 64'(mon_done), 64'h0);
        chk("rst_words", 64'(words_in_fifo), 64'h0);
        chk("rst_flags", 64'({fifo_overrun, fifo_underrun}), 64'h0);
        reset = 1'b0;

        // 1: ch0 three writes, three reads 8 cycles apart
        rreg(32'h080, 32'h0, "t1_status_idle");
        step(4'b0, 4'b0, 1'b1, 1'b0);
        chk("t1_active_after_run", 64'(active_program), 64'h1);
        repeat (3) step(4'b0001, 4'b0, 1'b0, 1'b0);
        idle(5); step(4'b0, 4'b0001, 1'b0, 1'b0);
        idle(7); step(4'b0, 4'b0001, 1'b0, 1'b0);
        idle(7); step(4'b0, 4'b0001, 1'b0, 1'b0);
        chk("t1_occ_zero", 64'(words_in_fifo), 64'h0);
        rreg(32'h080, 32'h0004_0000, "t1_status_run");
        rreg(32'h001, 32'd3, "t1_ibin1");
        rreg(32'h000, 32'd0, "t1_ibin0");
        rreg(32'h081, 32'd4, "t1_ic");

        // 2: ch1 back-to-back reads, one with a simultaneous write
        repeat (5) step(4'b0010, 4'b0, 1'b0, 1'b0);
        step(4'b0, 4'b0010, 1'b0, 1'b0);
        step(4'b0, 4'b0010, 1'b0, 1'b0);
        chk("t2_occ_before_wrrd", 64'(words_in_fifo), 64'h3_0000);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        chk("t2_occ_after_wrrd", 64'(words_in_fifo), 64'h3_0000);
        repeat (3) step(4'b0, 4'b0010, 1'b0, 1'b0);
        chk("t2_occ_empty", 64'(words_in_fifo), 64'h0);
        chk("t2_no_flags", 64'({fifo_overrun, fifo_underrun}), 64'h0);
        rreg(32'h100, 32'd5, "t2_ibin0");
        rreg(32'h180, 32'h0004_0000, "t2_status");

        // 3: ch2 read while empty
        step(4'b0, 4'b0100, 1'b0, 1'b0);
        chk("t3_underrun", 64'(fifo_underrun), 64'h4);
        chk("t3_occ_stays_zero", 64'(words_in_fifo), 64'h0);
        rreg(32'h280, 32'h0005_0000, "t3_status");

        // 4: end_program with ch3 holding two words
        repeat (2) step(4'b1000, 4'b0, 1'b0, 1'b0);
        step(4'b0, 4'b0, 1'b0, 1'b1);
        chk("t4_drain_active", 64'(active_program), 64'h1);
        chk("t4_drain_not_done", 64'(mon_done), 64'h0);
        step(4'b0, 4'b1000, 1'b0, 1'b0);
        idle(3);
        step(4'b0, 4'b1000, 1'b0, 1'b0);
        chk("t4_still_drain", 64'(active_program), 64'h1);
        idle(1);
        chk("t4_done", 64'(mon_done), 64'h1);
        chk("t4_inactive", 64'(active_program), 64'h0);
        step(4'b1000, 4'b0, 1'b0, 1'b0);
        step(4'b0, 4'b1000, 1'b0, 1'b0);
        rreg(32'h300, 32'd1, "t4_ibin0_frozen");
        rreg(32'h381, 32'd2, "t4_ic_frozen");
        rreg(32'h280, 32'h000D_0000, "t4_underrun_persists");
        rreg(32'h380, 32'h000C_0000, "t4_status_done");
        chk("t4_underrun_port", 64'(fifo_underrun), 64'h4);

        // 5: restart, saturation and out-of-range decode
        step(4'b0, 4'b0, 1'b1, 1'b0);
        chk("t5_flags_cleared", 64'(fifo_underrun), 64'h0);
        idle(20);
        repeat (10) step(4'b0001, 4'b0, 1'b0, 1'b0);
        rreg(32'h041, 32'd2, "t5_obin1");
        rreg(32'h040, 32'd15, "t5_obin0_saturated");
        rreg(32'h440, 32'd0, "t5_ch_out_of_range");
        rreg(32'h010, 32'd0, "t5_bin_out_of_range");
        rreg(32'h0C0, 32'd0, "t5_type3");
        rreg(32'h1041, 32'd0, "t5_high_addr");
        rreg(32'h041, 32'd8, "t5_obin1_later");

        // 6: reset mid-RUN, then run+end together
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_data_out_cleared", 64'(slave_data_out), 64'h0);
        chk("t6_active_cleared", 64'(active_program), 64'h0);
        chk("t6_done_cleared", 64'(mon_done), 64'h0);
        chk("t6_words_cleared", 64'(words_in_fifo), 64'h0);
        rreg(32'h080, 32'h0, "t6_status_idle");
        step(4'b0, 4'b0, 1'b1, 1'b1);
        chk("t6_run_wins", 64'(active_program), 64'h1);
        idle(1);
        rreg(32'h080, 32'h0004_0000, "t6_state_run");
        rreg(32'h081, 32'd2, "t6_ic");
        step(4'b0, 4'b0, 1'b0, 1'b1);
        chk("t6_drain_active", 64'(active_program), 64'h1);
        idle(1);
        chk("t6_drain_one_cycle", 64'(mon_done), 64'h1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL responses_missing got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
